// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Access sequencer states: issue from IDLE, wait in BUSY, commit in DONE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Byte address of the memory-mapped output register.
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  // Load data returned when a bus access is abandoned.
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  // Width of the bus wait counter (TIMEOUT must fit, 1..255).
  localparam int CTR_W = 8;

endpackage

// File: rtl/dmem_wait_ctr.sv
// Wait-cycle counter used to bound an outstanding memory-bus access.
// Latency: count advances one cycle after en_i; tc_o is combinational.
// Backpressure: none; clr_i has priority over en_i.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : zero the count (asserted when an access is issued)
//   en_i       : count this cycle (asserted while waiting for ack)
//   tc_o       : this counted cycle brings the count to TIMEOUT
module dmem_wait_ctr
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CTR_W-1:0] TC_VAL = CTR_W'(TIMEOUT);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  assign cnt_d = cnt_q + CTR_W'(1);

  // Flag the cycle in which the count reaches TIMEOUT, so an access gets
  // exactly TIMEOUT waiting cycles before it is abandoned.
  assign tc_o = en_i && (cnt_d == TC_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory stage: turns datapath loads/stores into req/ack bus transactions.
// Latency: 3 cycles minimum (issue, ack, commit); misaligned/MMIO complete in 1.
// Backpressure: stall holds the processor while a bus access is outstanding.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   memread, memwrite     : access request from the controller (both = write)
//   addr, wdata           : byte address and store data from the datapath
//   rdata, stall, bus_err : load data, processor freeze, one-cycle error pulse
//   mem_req/we/addr/wdata : bus request, held stable until mem_ack
//   mem_rdata, mem_ack    : bus response
//   io_out                : memory-mapped output register
// Build option: define DMEM_MMIO_EN to decode MMIO_ADDR to the internal io_out
// register; otherwise that address is an ordinary bus access and io_out is 0.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int AW      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [31:0]   io_out
);

  state_e          state_q;
  logic [31:0]     rdata_q;
  logic            bus_err_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [31:0]     mem_wdata_q;

  logic access;
  logic idle;
  logic mmio_hit;
  logic misalign;
  logic issue;
  logic timeout;

  assign access   = memread | memwrite;
  assign idle     = (state_q == S_IDLE);
  assign misalign = idle && access && (addr[1:0] != 2'b00);
  // New accesses are only taken in IDLE, so the instruction still presented
  // during DONE (its commit cycle) is never re-issued.
  assign issue    = idle && access && (addr[1:0] == 2'b00) && !mmio_hit;

  assign stall = issue || (state_q == S_BUSY);

  dmem_wait_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .clr_i (issue),
    .en_i  (state_q == S_BUSY),
    .tc_o  (timeout)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] io_out_q;

  assign mmio_hit = access && (addr == MMIO_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_q <= '0;
    end else if (idle && mmio_hit && memwrite) begin
      io_out_q <= wdata;
    end
  end

  assign io_out = io_out_q;
  // MMIO loads bypass the rdata register so they complete without a stall.
  assign rdata  = (idle && mmio_hit && !memwrite) ? io_out_q : rdata_q;
`else
  logic unused_addr;

  assign mmio_hit    = 1'b0;
  assign io_out      = '0;
  assign rdata       = rdata_q;
  assign unused_addr = ^{addr[31:AW+2], (addr == MMIO_ADDR)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (misalign) begin
            bus_err_q <= 1'b1;
            rdata_q   <= '0;
          end else if (issue) begin
            state_q     <= S_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= memwrite;
            mem_addr_q  <= addr[AW+1:2];
            mem_wdata_q <= wdata;
          end else if (mmio_hit && !memwrite) begin
            rdata_q <= io_out;
          end
        end
        S_BUSY: begin
          // An ack in the terminal cycle still completes normally.
          if (mem_ack) begin
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (timeout) begin
            rdata_q   <= ERR_DATA;
            bus_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomised scoreboard bench for dmem_bridge with a memory-bus responder.
// Latency: n/a.
// Backpressure: responder acks after a per-access delay, or never.
module tb_dmem_bridge;

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif
  localparam int NOACK = -1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] io_out;

  dmem_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .io_out    (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_n;
    bit          rd_now_chk;
    logic [31:0] rd_now;
    logic        err_now;
    logic        err_next;
    logic [31:0] rd_next;
    logic [31:0] io_next;
  } exp_t;

  typedef struct {
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wd;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] bus_mem [1024];
  logic [31:0] rdata_model = '0;
  logic [31:0] io_model = '0;
  int          resp_delay = 0;
  logic        late_ack = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Reference model: derive the expected outcome of one instruction from the
  // bridge's rules, then present it like a processor that holds its inputs
  // until stall drops.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int dly);
    exp_t e;
    bus_t b;
    int   n;
    e.rd_now_chk = 1'b1;
    e.err_now    = 1'b0;
    e.err_next   = 1'b0;
    if (a[1:0] != 2'b00) begin
      e.stall_n    = 0;
      e.rd_now_chk = 1'b0;
      e.err_next   = 1'b1;
      rdata_model  = '0;
    end else if (MMIO_EN && a == 32'hFFFF_FFF0) begin
      e.stall_n = 0;
      if (wr) io_model = wd;
      else    rdata_model = io_model;
    end else begin
      b.we = wr; b.waddr = a[11:2]; b.wd = wd;
      bus_q.push_back(b);
      if (dly == NOACK) begin
        e.stall_n   = 16;
        e.err_now   = 1'b1;
        rdata_model = 32'hDEAD_BEEF;
      end else begin
        e.stall_n = dly + 2;
        if (wr) ref_mem[a[11:2]] = wd;
        else    rdata_model = ref_mem[a[11:2]];
      end
    end
    e.rd_now  = rdata_model;
    e.rd_next = rdata_model;
    e.io_next = io_model;
    exp_q.push_back(e);

    @(posedge clk); #1;
    memread = rd; memwrite = wr; addr = a; wdata = wd; resp_delay = dly;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 40) begin
        vectors++; miscompares++;
        $display("FAIL commit_timeout: stall still 1 after %0d cycles, required release", n);
        finish_run();
      end
    end
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  // Memory-bus responder: acks on BUSY cycle index resp_delay.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk); #1;
      mem_ack   = late_ack;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (k == resp_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = bus_mem[mem_addr];
          if (mem_we) bus_mem[mem_addr] = mem_wdata;
        end
        k++;
      end else begin
        k = 0;
      end
    end
  end

  // Monitor: pops bus and commit expectations as the DUT presents them.
  initial begin
    int   stall_n;
    bit   pend_next;
    logic prev_req;
    exp_t e;
    exp_t nx;
    bus_t cur;
    stall_n = 0; pend_next = 1'b0; prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_n = 0; pend_next = 1'b0; prev_req = 1'b0;
        continue;
      end
      if (pend_next) begin
        check("bus_err_after_commit", 32'(bus_err), 32'(nx.err_next));
        check("rdata_after_commit", rdata, nx.rd_next);
        check("io_out_after_commit", io_out, nx.io_next);
        pend_next = 1'b0;
      end
      if (mem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
        end else begin
          cur = bus_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(cur.we));
          check("mem_addr", 32'(mem_addr), 32'(cur.waddr));
          if (cur.we) check("mem_wdata", mem_wdata, cur.wd);
        end
      end else if (mem_req) begin
        check("mem_we_stable", 32'(mem_we), 32'(cur.we));
        check("mem_addr_stable", 32'(mem_addr), 32'(cur.waddr));
        if (cur.we) check("mem_wdata_stable", mem_wdata, cur.wd);
      end
      prev_req = mem_req;
      if (stall) begin
        stall_n++;
      end else if (memread || memwrite) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stall_cycles", 32'(stall_n), 32'(e.stall_n));
          check("bus_err_at_commit", 32'(bus_err), 32'(e.err_now));
          check("mem_req_at_commit", 32'(mem_req), 32'd0);
          if (e.rd_now_chk) check("rdata_at_commit", rdata, e.rd_now);
          nx = e;
          pend_next = 1'b1;
        end
        stall_n = 0;
      end
    end
  end

  initial begin
    bit          rd, wr;
    int          kind, dly;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[10'h10] = 32'h1234_5678;
    bus_mem[10'h10] = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rdata", rdata, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_bus_err", 32'(bus_err), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_io_out", io_out, 32'd0);

    do_access(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1);
    do_access(1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 2);
    do_access(1'b1, 1'b0, 32'h0000_0008, 32'd0, 0);
    do_access(1'b1, 1'b0, 32'h0000_0004, 32'd0, NOACK);
    do_access(1'b1, 1'b0, 32'h0000_0006, 32'd0, 0);

    // Reset in the middle of a bus wait, then a stray ack while idle.
    begin
      bus_t b;
      b.we = 1'b0; b.waddr = 10'h40; b.wd = '0;
      bus_q.push_back(b);
      @(posedge clk); #1;
      memread = 1'b1; addr = 32'h0000_0100; resp_delay = NOACK;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1; memread = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("mem_req_after_reset", 32'(mem_req), 32'd0);
      check("stall_after_reset", 32'(stall), 32'd0);
      rdata_model = '0;
      io_model    = '0;
      late_ack    = 1'b1;
      repeat (2) begin
        @(negedge clk);
        check("late_ack_stall", 32'(stall), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_rdata", rdata, 32'd0);
      end
      @(posedge clk); #1 late_ack = 1'b0;
      @(posedge clk); #1;
    end

    do_access(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 0);
    do_access(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, 1);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
      dly  = ($urandom_range(0, 9) == 0) ? NOACK : $urandom_range(0, 4);
      rd   = 1'b0;
      wr   = 1'b0;
      if (kind <= 3) begin
        rd = 1'b1;
      end else if (kind <= 6) begin
        wr = 1'b1;
      end else if (kind == 7) begin
        rd = 1'b1; wr = 1'b1;
      end else if (kind == 8) begin
        a  = a | 32'($urandom_range(1, 3));
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
      end else begin
        a  = 32'hFFFF_FFF0;
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
      end
      do_access(rd, wr, a, $urandom, dly);
    end

    repeat (3) @(negedge clk);
    check("pending_commits", 32'(exp_q.size()), 32'd0);
    check("pending_bus_txns", 32'(bus_q.size()), 32'd0);
    finish_run();
  end

  initial begin
    #500000;
    vectors++; miscompares++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    finish_run();
  end

endmodule
